// File: rtl/alu_cmd_sequencer.sv
// Single-issue command master for the 8-bit combinational ALU: it accepts a command,
// drives registered operands into the ALU, writes Y back to the register file and returns the result.
module alu_cmd_sequencer #(
    parameter int NREG = 4,
    parameter int RAW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [3:0]     cmd_op,
    input  logic [RAW-1:0] cmd_rd,
    input  logic [RAW-1:0] cmd_ra,
    input  logic [RAW-1:0] cmd_rb,
    input  logic [7:0]     cmd_imm,
    output logic [7:0]     alu_a,
    output logic [7:0]     alu_b,
    output logic [2:0]     alu_sel,
    input  logic [7:0]     alu_y,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [7:0]     res_data,
    output logic [RAW-1:0] res_rd,
    output logic           res_zero,
    output logic           res_dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_reg;
    state_t         state_next;

    logic           accept;
    logic           ld_imm;
    logic           wr_en;
    logic [RAW-1:0] wr_addr;
    logic [7:0]     wr_data;

    logic [RAW-1:0] rd_reg;
    logic [7:0]     alu_a_reg;
    logic [7:0]     alu_b_reg;
    logic [2:0]     alu_sel_reg;
    logic [7:0]     res_data_reg;
    logic [RAW-1:0] res_rd_reg;
    logic           res_dz_reg;

    logic [7:0]     rf_rd [NREG];

    // Register file: one register per entry so reset can clear every entry at once.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf
            logic [7:0] q_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= 8'h00;
                end else if (wr_en && (wr_addr == RAW'(gi))) begin
                    q_reg <= wr_data;
                end
            end
            assign rf_rd[gi] = q_reg;
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        ld_imm     = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = rd_reg;
        wr_data    = alu_y;
        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_op[3]) begin
                        ld_imm     = 1'b1;
                        wr_en      = 1'b1;
                        wr_addr    = cmd_rd;
                        wr_data    = cmd_imm;
                        state_next = RESP;
                    end else begin
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                wr_en      = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operands are sampled at accept, so a destination equal to a source sees the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            rd_reg       <= '0;
            alu_a_reg    <= 8'h00;
            alu_b_reg    <= 8'h00;
            alu_sel_reg  <= 3'b000;
            res_data_reg <= 8'h00;
            res_rd_reg   <= '0;
            res_dz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && !cmd_op[3]) begin
                alu_a_reg   <= rf_rd[cmd_ra];
                alu_b_reg   <= rf_rd[cmd_rb];
                alu_sel_reg <= cmd_op[2:0];
                rd_reg      <= cmd_rd;
            end
            if (ld_imm) begin
                res_data_reg <= cmd_imm;
                res_rd_reg   <= cmd_rd;
                res_dz_reg   <= 1'b0;
            end
            if (state_reg == EXEC) begin
                res_data_reg <= alu_y;
                res_rd_reg   <= rd_reg;
                res_dz_reg   <= (alu_sel_reg == 3'b011) && (alu_b_reg == 8'h00);
            end
        end
    end

    assign cmd_ready = (state_reg == IDLE);
    assign res_valid = (state_reg == RESP);
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = alu_sel_reg;
    assign res_data  = res_data_reg;
    assign res_rd    = res_rd_reg;
    assign res_dz    = res_dz_reg;
    assign res_zero  = (res_data_reg == 8'h00);

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: a local ALU feeds alu_y, and a queue-based model predicts
// every response and its timing. Literal checks pin the model to hand-computed values.
module tb_alu_cmd_sequencer;
    localparam int NREG = 4;
    localparam int RAW  = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [3:0]     cmd_op = 4'h0;
    logic [RAW-1:0] cmd_rd = '0;
    logic [RAW-1:0] cmd_ra = '0;
    logic [RAW-1:0] cmd_rb = '0;
    logic [7:0]     cmd_imm = 8'h00;
    logic [7:0]     alu_a;
    logic [7:0]     alu_b;
    logic [2:0]     alu_sel;
    logic [7:0]     alu_y;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [7:0]     res_data;
    logic [RAW-1:0] res_rd;
    logic           res_zero;
    logic           res_dz;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.NREG(NREG), .RAW(RAW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_rd(res_rd), .res_zero(res_zero), .res_dz(res_dz)
    );

    // The ALU the sequencer drives: 8-bit modulo results, divide by zero gives 0xFF.
    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return 8'(a * b);
            3'd3:    return (b == 8'h00) ? 8'hFF : a / b;
            3'd4:    return 8'(a << b);
            3'd5:    return a & b;
            3'd6:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb alu_y = alu_fn(alu_a, alu_b, alu_sel);

    typedef struct {
        logic [7:0]     data;
        logic [RAW-1:0] rd;
        logic           dz;
        int             rdy;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       dz;
        logic       zero;
    } obs_t;

    exp_t       exp_q[$];
    obs_t       obs_q[$];
    logic [7:0] rf_m [NREG];
    logic [7:0] m_a = 8'h00;
    logic [7:0] m_b = 8'h00;
    logic [2:0] m_sel = 3'b000;
    int         cyc = 0;
    int         checks = 0;
    int         fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        bit expv;
        if (!rst) begin
            expv = (exp_q.size() > 0) && (cyc >= exp_q[0].rdy);
            check("res_valid", res_valid, expv);
            check("cmd_ready", cmd_ready, exp_q.size() == 0);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_sel", alu_sel, m_sel);
            if (expv && res_valid) begin
                check("res_data", res_data, exp_q[0].data);
                check("res_rd", res_rd, exp_q[0].rd);
                check("res_zero", res_zero, exp_q[0].data == 8'h00);
                check("res_dz", res_dz, exp_q[0].dz);
            end
        end
    end

    // A response is consumed on the edge where valid and ready are both high.
    always @(posedge clk) begin
        if (!rst && res_valid && res_ready && exp_q.size() > 0) begin
            obs_q.push_back('{data: res_data, dz: res_dz, zero: res_zero});
            void'(exp_q.pop_front());
        end
    end

    task automatic clear_model();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < NREG; i++) rf_m[i] = 8'h00;
        m_a = 8'h00;
        m_b = 8'h00;
        m_sel = 3'b000;
    endtask

    // Issues one command; returns on the falling edge after the accept edge.
    task automatic run(input logic [3:0] op, input int rd, input int ra, input int rb, input logic [7:0] imm);
        int   n;
        int   k;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_rd = RAW'(rd);
        cmd_ra = RAW'(ra);
        cmd_rb = RAW'(rb);
        cmd_imm = imm;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            $display("FAIL accept_timeout: cmd_ready got 0, expected 1");
            fails++;
            checks++;
        end
        k = cyc;
        @(posedge clk);
        e.rd = RAW'(rd);
        if (op[3]) begin
            e.data = imm;
            e.dz = 1'b0;
            e.rdy = k + 1;
        end else begin
            m_a = rf_m[ra];
            m_b = rf_m[rb];
            m_sel = op[2:0];
            e.data = alu_fn(m_a, m_b, m_sel);
            e.dz = (m_sel == 3'b011) && (m_b == 8'h00);
            e.rdy = k + 2;
        end
        rf_m[rd] = e.data;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 40 && exp_q.size() > 0; n++) @(negedge clk);
        checks++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL resp_timeout: got no response, expected one within 40 cycles");
            exp_q.delete();
        end
    endtask

    task automatic expect_res(input string nm, input logic [7:0] data, input logic dz);
        obs_t o;
        checks++;
        if (obs_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got no result, expected %0h", nm, data);
        end else begin
            o = obs_q.pop_front();
            checks--;
            check({nm, "_data"}, o.data, data);
            check({nm, "_dz"}, o.dz, dz);
            check({nm, "_zero"}, o.zero, data == 8'h00);
        end
        $display("txn %s: res_data=%0h res_dz=%0b", nm, o.data, o.dz);
    endtask

    task automatic ldi(input int rd, input logic [7:0] imm, input string nm);
        run(4'b1000, rd, 0, 0, imm);
        wait_done();
        expect_res(nm, imm, 1'b0);
    endtask

    task automatic aluop(input logic [2:0] sel, input int rd, input int ra, input int rb,
                         input logic [7:0] exp_data, input logic exp_dz, input string nm);
        run({1'b0, sel}, rd, ra, rb, 8'h00);
        wait_done();
        expect_res(nm, exp_data, exp_dz);
    endtask

    initial begin
        clear_model();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_res_data", res_data, 8'h00);
        check("rst_res_rd", res_rd, 0);
        check("rst_res_dz", res_dz, 1'b0);
        check("rst_res_zero", res_zero, 1'b1);
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_alu_sel", alu_sel, 3'b000);

        ldi(0, 8'h05, "ldi_r0_05");
        ldi(1, 8'h03, "ldi_r1_03");
        aluop(3'd0, 2, 0, 1, 8'h08, 1'b0, "add_5_3");
        aluop(3'd6, 3, 2, 2, 8'h08, 1'b0, "or_r2_r2");

        ldi(0, 8'h03, "ldi_r0_03");
        ldi(1, 8'h05, "ldi_r1_05");
        aluop(3'd1, 2, 0, 1, 8'hFE, 1'b0, "sub_3_5");

        ldi(0, 8'h14, "ldi_r0_14");
        aluop(3'd2, 2, 0, 0, 8'h90, 1'b0, "mul_14_14");

        ldi(0, 8'h01, "ldi_r0_01");
        ldi(1, 8'h09, "ldi_r1_09");
        aluop(3'd4, 2, 0, 1, 8'h00, 1'b0, "shl_1_9");

        ldi(0, 8'h09, "ldi_r0_09");
        ldi(1, 8'h00, "ldi_r1_00");
        aluop(3'd3, 2, 0, 1, 8'hFF, 1'b1, "div_by_0");
        ldi(1, 8'h03, "ldi_r1_03b");
        aluop(3'd3, 2, 0, 1, 8'h03, 1'b0, "div_9_3");

        // Consumer stalls for five cycles; the response must hold.
        res_ready = 1'b0;
        run(4'b1000, 3, 0, 0, 8'h77);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", res_valid, 1'b1);
            check("hold_data", res_data, 8'h77);
            check("hold_cmd_ready", cmd_ready, 1'b0);
            @(negedge clk);
        end
        res_ready = 1'b1;
        wait_done();
        expect_res("ldi_hold", 8'h77, 1'b0);
        @(negedge clk);
        check("release_cmd_ready", cmd_ready, 1'b1);

        ldi(1, 8'h81, "ldi_r1_81");
        aluop(3'd0, 1, 1, 1, 8'h02, 1'b0, "add_self_wrap");
        aluop(3'd6, 0, 1, 1, 8'h02, 1'b0, "or_r1_r1");

        // Reset while the ALU op is in EXEC: no response, register file cleared.
        ldi(1, 8'h11, "ldi_r1_11");
        run(4'b0000, 0, 1, 1, 8'h00);
        #2 rst = 1'b1;
        clear_model();
        @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_valid", res_valid, 1'b0);
        end
        check("post_rst_obs_empty", obs_q.size(), 0);
        aluop(3'd0, 2, 0, 1, 8'h00, 1'b0, "add_after_rst");

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
